shift_word_tx: RTL and testbench

- Parallel-in/serial-out word transmitter: the sending end for our 4-bit universal shift register's serial inputs (SIL/SIR).
- Loads a WIDTH-bit word on a load/ready handshake, then shifts it out one bit per bit-tick, LSB-first or MSB-first.
- Drives a frame-valid strobe and a one-cycle done pulse.
- Sits between Basys3 switch/button inputs and any serial-consuming register or LED display.

---
 rtl/shift_word_tx_pkg.sv | 13 +
 rtl/shift_word_tx_tick_gen.sv | 28 ++
 rtl/shift_word_tx.sv | 130 +++++++++++++
 tb/tb_shift_word_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_word_tx_pkg.sv
// Shared types and constants for the shift_word_tx serial word transmitter.
package shift_word_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

endpackage

// File: rtl/shift_word_tx_tick_gen.sv
// Free-running bit-tick divider: one-clk tick whenever the counter sits at all-ones.
// Used by shift_word_tx only when SHIFT_WORD_TX_TICK_DIV_EN is defined.
module tick_gen #(
  parameter int DIV_BITS = 26
) (
  input  logic clk,
  input  logic clear,
  input  logic restart,
  output logic tick
);

  logic [DIV_BITS-1:0] cnt_r;
  logic                tick_r;

  // Divider counter and registered tick, aligned so tick is high while cnt_r is all-ones
  always_ff @(posedge clk) begin
    if (clear || restart) begin
      cnt_r  <= {DIV_BITS{1'b0}};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_r + DIV_BITS'(1);
      tick_r <= ((cnt_r + DIV_BITS'(1)) == {DIV_BITS{1'b1}});
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/shift_word_tx.sv
// Parallel-in/serial-out word transmitter with load/ready handshake and done pulse.
// Define SHIFT_WORD_TX_TICK_DIV_EN to pace bits with the internal 2^DIV_BITS divider.
module shift_word_tx
  import shift_word_tx_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DIV_BITS = 26
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  input  logic             msb_first,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || DIV_BITS < 1) begin : g_param_check
    $error("shift_word_tx: WIDTH must be >= 2 and DIV_BITS >= 1");
  end

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   shreg_r, shreg_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               dir_r, dir_s;
  logic               load_acc_s;
  logic               tick_s;
  logic               sout_s;
  logic               ready_r, busy_r, sout_r, sout_valid_r, done_r;

`ifdef SHIFT_WORD_TX_TICK_DIV_EN
  tick_gen #(.DIV_BITS(DIV_BITS)) u_tick_gen (
    .clk     (clk),
    .clear   (clear),
    .restart (load_acc_s),
    .tick    (tick_s)
  );
`else
  assign tick_s = 1'b1;
`endif

  // Next-state, datapath and next serial bit; outputs are registered from these
  always_comb begin
    state_s    = state_r;
    shreg_s    = shreg_r;
    cnt_s      = cnt_r;
    dir_s      = dir_r;
    load_acc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (load) begin
          load_acc_s = 1'b1;
          shreg_s    = data_in;
          dir_s      = msb_first;
          cnt_s      = {CNT_W{1'b0}};
          state_s    = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (tick_s) begin
          if (cnt_r == LAST_CNT) begin
            state_s = DONE;
          end else begin
            // vacated bit fills with zero on the far end
            if (dir_r == DIR_MSB) begin
              shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
            end else begin
              shreg_s = {1'b0, shreg_r[WIDTH-1:1]};
            end
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (state_s == SHIFT) begin
      sout_s = (dir_s == DIR_MSB) ? shreg_s[WIDTH-1] : shreg_s[0];
    end else begin
      sout_s = 1'b0;
    end
  end

  // State, datapath and registered outputs; clear overrides everything
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r      <= IDLE;
      shreg_r      <= {WIDTH{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      dir_r        <= DIR_LSB;
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
      sout_r       <= 1'b0;
      sout_valid_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      shreg_r      <= shreg_s;
      cnt_r        <= cnt_s;
      dir_r        <= dir_s;
      ready_r      <= (state_s == IDLE);
      busy_r       <= (state_s != IDLE);
      sout_r       <= sout_s;
      sout_valid_r <= (state_s == SHIFT);
      done_r       <= (state_s == DONE);
    end
  end

  assign ready      = ready_r;
  assign busy       = busy_r;
  assign sout       = sout_r;
  assign sout_valid = sout_valid_r;
  assign done       = done_r;

endmodule

// File: tb/tb_shift_word_tx.sv
// Directed self-checking bench for shift_word_tx (WIDTH=4); the divider test runs
// instead of the fast-link tests when SHIFT_WORD_TX_TICK_DIV_EN is defined.
module tb_shift_word_tx;

  logic       clk = 1'b0;
  logic       clear;
  logic [3:0] data_in;
  logic       msb_first;
  logic       load;
  logic       ready, busy, sout, sout_valid, done;

  int errors = 0;
  int checks = 0;

  shift_word_tx #(.WIDTH(4), .DIV_BITS(3)) dut (
    .clk        (clk),
    .clear      (clear),
    .data_in    (data_in),
    .msb_first  (msb_first),
    .load       (load),
    .ready      (ready),
    .busy       (busy),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic reset_dut();
    clear = 1'b1; load = 1'b0; data_in = 4'b0000; msb_first = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({ready, busy, sout, sout_valid, done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset: {rdy,busy,sout,vld,done} got %b want 10000",
               {ready, busy, sout, sout_valid, done});
    end
  endtask

  // LSB-first and MSB-first frames of the same word
  task automatic test_directions();
    logic [3:0] words [2] = '{4'b1011, 4'b1011};
    logic       dirs  [2] = '{1'b0, 1'b1};
    logic [3:0] seqs  [2] = '{4'b1101, 4'b1011}; // seq[3] is first bit out
    for (int f = 0; f < 2; f++) begin
      data_in = words[f]; msb_first = dirs[f]; load = 1'b1;
      @(negedge clk);
      load = 1'b0; data_in = 4'b0000; msb_first = ~dirs[f];
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({sout, sout_valid, busy, ready, done} !== {seqs[f][3-i], 4'b1100}) begin
          errors++;
          $display("FAIL dir%0d bit%0d: {sout,vld,busy,rdy,done} got %b want %b", f, i,
                   {sout, sout_valid, busy, ready, done}, {seqs[f][3-i], 4'b1100});
        end
        @(negedge clk);
      end
      checks++;
      if ({done, sout_valid, busy, ready, sout} !== 5'b10100) begin
        errors++;
        $display("FAIL dir%0d done: {done,vld,busy,rdy,sout} got %b want 10100", f,
                 {done, sout_valid, busy, ready, sout});
      end
      @(negedge clk);
      checks++;
      if ({ready, busy, done, sout_valid} !== 4'b1000) begin
        errors++;
        $display("FAIL dir%0d idle: {rdy,busy,done,vld} got %b want 1000", f,
                 {ready, busy, done, sout_valid});
      end
    end
  endtask

  task automatic test_load_while_busy();
    logic [3:0] seq = 4'b0110; // first bit out is seq[3]
    int dones = 0;
    data_in = 4'b0110; msb_first = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin load = 1'b1; data_in = 4'b1111; msb_first = 1'b1; end
      else begin load = 1'b0; end
      checks++;
      if (sout !== seq[3-i] || sout_valid !== 1'b1) begin
        errors++;
        $display("FAIL busy_load bit%0d: sout/vld got %b%b want %b1", i, sout, sout_valid, seq[3-i]);
      end
      @(negedge clk);
    end
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 1 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_load end: dones=%0d rdy=%b busy=%b want 1 1 0", dones, ready, busy);
    end
  endtask

  task automatic test_clear_mid();
    logic [3:0] seq = 4'b1100;
    data_in = 4'b1001; msb_first = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if ({ready, busy, sout, sout_valid, done} !== 5'b10000) begin
      errors++;
      $display("FAIL clear_mid: {rdy,busy,sout,vld,done} got %b want 10000",
               {ready, busy, sout, sout_valid, done});
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL clear_nodone: done/busy got %b%b want 00", done, busy);
      end
    end
    data_in = 4'b0011; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sout !== seq[3-i] || sout_valid !== 1'b1) begin
        errors++;
        $display("FAIL clear_reload bit%0d: sout/vld got %b%b want %b1", i, sout, sout_valid, seq[3-i]);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL clear_reload done: got %b want 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq_a = 4'b0101; // 1010 LSB-first: 0,1,0,1
    logic [3:0] seq_b = 4'b1010; // 0101 LSB-first: 1,0,1,0
    logic [3:0] seq;
    msb_first = 1'b0; data_in = 4'b1010; load = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      seq = (f % 2 == 0) ? seq_a : seq_b;
      data_in = (f % 2 == 0) ? 4'b0101 : 4'b1010;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({sout, sout_valid, ready} !== {seq[3-i], 2'b10}) begin
          errors++;
          $display("FAIL b2b f%0d bit%0d: {sout,vld,rdy} got %b want %b", f, i,
                   {sout, sout_valid, ready}, {seq[3-i], 2'b10});
        end
        @(negedge clk);
      end
      checks++;
      if ({done, sout_valid, ready} !== 3'b100) begin
        errors++;
        $display("FAIL b2b f%0d done: {done,vld,rdy} got %b want 100", f, {done, sout_valid, ready});
      end
      @(negedge clk);
      if (f == 2) load = 1'b0;
      checks++;
      if ({done, sout_valid, ready, busy} !== 4'b0010) begin
        errors++;
        $display("FAIL b2b f%0d idle: {done,vld,rdy,busy} got %b want 0010", f,
                 {done, sout_valid, ready, busy});
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b stop: busy got %b want 0", busy);
    end
  endtask

  task automatic test_divider();
    logic [3:0] seq = 4'b0011; // 1100 LSB-first: 0,0,1,1
    int bad = 0;
    data_in = 4'b1100; msb_first = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (sout !== seq[3 - c / 8] || sout_valid !== 1'b1 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL div_hold: bad cycles got %0d want 0", bad);
    end
    checks++;
    if (done !== 1'b1 || sout_valid !== 1'b0) begin
      errors++;
      $display("FAIL div_done: done/vld got %b%b want 10", done, sout_valid);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL div_ready: got %b want 1", ready);
    end
  endtask

  initial begin
    test_reset();
`ifdef SHIFT_WORD_TX_TICK_DIV_EN
    test_divider();
`else
    test_directions();
    test_load_while_busy();
    test_clear_mid();
    test_back_to_back();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
